dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 84 ++++++++
 tb/tb_dmem_responder.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle big-endian data memory (req_valid/MemWrite/addr/wdata/DSize/loadSign in; stall/done/dMemValue/misalign out)
module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        MemWrite,
  input  logic [0:31] addr,
  input  logic [0:31] wdata,
  input  logic [0:1]  DSize,
  input  logic        loadSign,
  output logic        stall,
  output logic        done,
  output logic [0:31] dMemValue,
  output logic        misalign
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t r_state, w_next;
  logic [3:0] r_cnt;
  logic [0:31] r_addr, r_wdata;
  logic [0:1] r_size;
  logic r_we, r_sign;
  logic [0:31] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [0:31] w_word, w_load, w_store;
  logic [0:7] w_byte;
  logic [0:15] w_half;
  logic w_hw, w_bt, w_mis, w_fire, w_accept;
  assign w_idx = r_addr[30-DEPTH_LOG2:29];
  assign w_word = r_mem[w_idx];
  assign w_byte = w_word[{r_addr[30:31], 3'b000} +: 8];
  assign w_half = w_word[{r_addr[30], 4'b0000} +: 16];
  assign w_hw = r_size == 2'b01;
  assign w_bt = r_size == 2'b10;
  assign w_mis = w_hw ? r_addr[31] : (!w_bt && r_addr[30:31] != 2'b00);
  assign w_load = w_bt ? {{24{r_sign & w_byte[0]}}, w_byte}
                : w_hw ? {{16{r_sign & w_half[0]}}, w_half} : w_word;
  assign w_fire = r_state == BUSY && r_cnt == 4'd0;
  assign w_accept = r_state == IDLE && req_valid;
  assign stall = w_accept || r_state == BUSY;
  always_comb begin
    w_store = w_word;
    if (w_bt) w_store[{r_addr[30:31], 3'b000} +: 8] = r_wdata[24:31];
    else if (w_hw) w_store[{r_addr[30], 4'b0000} +: 16] = r_wdata[16:31];
    else w_store = r_wdata;
  end
  always_comb begin
    w_next = r_state == IDLE ? (req_valid ? BUSY : IDLE)
           : r_state == BUSY ? (r_cnt == 4'd0 ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= 4'd0;
      done <= 1'b0;
      misalign <= 1'b0;
      dMemValue <= 32'd0;
      r_addr <= 32'd0;
      r_wdata <= 32'd0;
      r_size <= 2'b00;
      r_we <= 1'b0;
      r_sign <= 1'b0;
    end else begin
      r_state <= w_next;
      done <= w_fire;
      misalign <= w_fire && w_mis;
      if (w_accept) begin
        r_addr <= addr;
        r_wdata <= wdata;
        r_size <= DSize;
        r_we <= MemWrite;
        r_sign <= loadSign;
        r_cnt <= 4'(LATENCY - 1);
      end else if (r_state == BUSY && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (w_fire) dMemValue <= (r_we || w_mis) ? 32'd0 : w_load;
    end
  end
  // reset sampled high at the completing edge aborts the store
  always_ff @(posedge clk) begin
    if (w_fire && r_we && !w_mis && !reset) r_mem[w_idx] <= w_store;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
  logic clk = 1'b0, reset = 1'b0, req_valid = 1'b0, MemWrite = 1'b0, loadSign = 1'b0;
  logic [0:31] addr = 32'd0, wdata = 32'd0;
  logic [0:1] DSize = 2'b00;
  logic stall, done, misalign;
  logic [0:31] dMemValue;
  int n_cmp = 0, n_bad = 0;
  int n;
  logic [0:31] val;
  logic mis, dn1, dn2;
  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .DSize(DSize), .loadSign(loadSign),
    .stall(stall), .done(done), .dMemValue(dMemValue), .misalign(misalign)
  );
  always #5 clk = ~clk;
  task automatic access(input logic we, input logic [0:31] a, input logic [0:31] wd,
                        input logic [0:1] sz, input logic sgn, input bit scramble);
    @(negedge clk);
    req_valid = 1'b1; MemWrite = we; addr = a; wdata = wd; DSize = sz; loadSign = sgn;
    n = 0;
    #1;
    while (stall && n < 40) begin
      n++;
      @(posedge clk); #1;
      if (scramble) begin
        addr = ~a; wdata = ~wd; MemWrite = ~we; DSize = ~sz; loadSign = ~sgn;
      end
    end
    dn1 = done; val = dMemValue; mis = misalign;
    req_valid = 1'b0;
    @(posedge clk); #1;
    dn2 = done;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    #1;
    n_cmp += 4;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got %b want 0", stall); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", done); end
    if (misalign !== 1'b0) begin n_bad++; $display("FAIL reset_misalign got %b want 0", misalign); end
    if (dMemValue !== 32'd0) begin n_bad++; $display("FAIL reset_value got %h want 0", dMemValue); end
    req_valid = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin n_bad++; $display("FAIL reset_stall_follows_req got %b want 1", stall); end
    req_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
  endtask
  task automatic test_word;
    access(1'b1, 32'h100, 32'h12345678, 2'b00, 1'b0, 0);
    n_cmp += 4;
    if (n !== 3) begin n_bad++; $display("FAIL st_word_stall_cycles got %0d want 3", n); end
    if (dn1 !== 1'b1) begin n_bad++; $display("FAIL st_word_done got %b want 1", dn1); end
    if (dn2 !== 1'b0) begin n_bad++; $display("FAIL st_word_done_width got %b want 0", dn2); end
    if (val !== 32'd0) begin n_bad++; $display("FAIL st_word_value got %h want 0", val); end
    access(1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 0);
    n_cmp += 4;
    if (n !== 3) begin n_bad++; $display("FAIL ld_word_stall_cycles got %0d want 3", n); end
    if (val !== 32'h12345678) begin n_bad++; $display("FAIL ld_word got %h want 12345678", val); end
    if (mis !== 1'b0) begin n_bad++; $display("FAIL ld_word_misalign got %b want 0", mis); end
    if (dMemValue !== 32'h12345678) begin n_bad++; $display("FAIL ld_word_hold got %h want 12345678", dMemValue); end
  endtask
  task automatic test_byte;
    access(1'b1, 32'h200, 32'h11223344, 2'b00, 1'b0, 0);
    access(1'b1, 32'h201, 32'hFFFFFFAB, 2'b10, 1'b0, 0);
    access(1'b0, 32'h200, 32'h0, 2'b00, 1'b0, 0);
    n_cmp++;
    if (val !== 32'h11AB3344) begin n_bad++; $display("FAIL byte_store_merge got %h want 11ab3344", val); end
    access(1'b0, 32'h201, 32'h0, 2'b10, 1'b1, 0);
    n_cmp++;
    if (val !== 32'hFFFFFFAB) begin n_bad++; $display("FAIL ld_byte_signed got %h want ffffffab", val); end
    access(1'b0, 32'h201, 32'h0, 2'b10, 1'b0, 0);
    n_cmp++;
    if (val !== 32'h000000AB) begin n_bad++; $display("FAIL ld_byte_unsigned got %h want 000000ab", val); end
    access(1'b0, 32'h203, 32'h0, 2'b10, 1'b1, 0);
    n_cmp++;
    if (val !== 32'h00000044) begin n_bad++; $display("FAIL ld_byte3_signed got %h want 00000044", val); end
  endtask
  task automatic test_half;
    access(1'b1, 32'h300, 32'h8000FFFF, 2'b00, 1'b0, 0);
    access(1'b0, 32'h300, 32'h0, 2'b01, 1'b1, 0);
    n_cmp++;
    if (val !== 32'hFFFF8000) begin n_bad++; $display("FAIL ld_half_signed got %h want ffff8000", val); end
    access(1'b0, 32'h302, 32'h0, 2'b01, 1'b0, 0);
    n_cmp++;
    if (val !== 32'h0000FFFF) begin n_bad++; $display("FAIL ld_half_unsigned got %h want 0000ffff", val); end
    access(1'b1, 32'h302, 32'h00001234, 2'b01, 1'b0, 0);
    access(1'b0, 32'h300, 32'h0, 2'b11, 1'b0, 0);
    n_cmp++;
    if (val !== 32'h80001234) begin n_bad++; $display("FAIL half_store_merge got %h want 80001234", val); end
  endtask
  task automatic test_misalign;
    access(1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 0);
    access(1'b0, 32'h103, 32'h0, 2'b00, 1'b0, 0);
    n_cmp += 5;
    if (n !== 3) begin n_bad++; $display("FAIL mis_ld_stall_cycles got %0d want 3", n); end
    if (dn1 !== 1'b1) begin n_bad++; $display("FAIL mis_ld_done got %b want 1", dn1); end
    if (mis !== 1'b1) begin n_bad++; $display("FAIL mis_ld_flag got %b want 1", mis); end
    if (val !== 32'd0) begin n_bad++; $display("FAIL mis_ld_value got %h want 0", val); end
    if (misalign !== 1'b0) begin n_bad++; $display("FAIL mis_flag_clears got %b want 0", misalign); end
    access(1'b1, 32'h101, 32'h0000BEEF, 2'b01, 1'b0, 0);
    n_cmp++;
    if (mis !== 1'b1) begin n_bad++; $display("FAIL mis_st_flag got %b want 1", mis); end
    access(1'b0, 32'h100, 32'h0, 2'b00, 1'b0, 0);
    n_cmp += 2;
    if (val !== 32'h12345678) begin n_bad++; $display("FAIL mis_st_no_write got %h want 12345678", val); end
    if (mis !== 1'b0) begin n_bad++; $display("FAIL aligned_misalign got %b want 0", mis); end
    access(1'b0, 32'h102, 32'h0, 2'b01, 1'b0, 0);
    n_cmp++;
    if (mis !== 1'b0 || val !== 32'h00005678) begin n_bad++; $display("FAIL half_aligned got mis=%b %h want 0 00005678", mis, val); end
  endtask
  task automatic test_wrap;
    access(1'b1, 32'h1004, 32'hCAFEF00D, 2'b00, 1'b0, 0);
    access(1'b0, 32'h0004, 32'h0, 2'b00, 1'b0, 0);
    n_cmp++;
    if (val !== 32'hCAFEF00D) begin n_bad++; $display("FAIL wrap got %h want cafef00d", val); end
  endtask
  task automatic test_latched;
    access(1'b1, 32'h400, 32'h0BADC0DE, 2'b00, 1'b0, 1);
    access(1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 1);
    n_cmp++;
    if (val !== 32'h0000000B) begin n_bad++; $display("FAIL latched_inputs got %h want 0000000b", val); end
    access(1'b0, 32'h400, 32'h0, 2'b00, 1'b0, 0);
    n_cmp++;
    if (val !== 32'h0BADC0DE) begin n_bad++; $display("FAIL latched_store got %h want 0badc0de", val); end
  endtask
  task automatic test_reset_mid;
    access(1'b1, 32'h40, 32'h55AA55AA, 2'b00, 1'b0, 0);
    access(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 0);
    @(negedge clk);
    req_valid = 1'b1; MemWrite = 1'b1; addr = 32'h40; wdata = 32'hDEADBEEF; DSize = 2'b00;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_cmp += 3;
    if (dMemValue !== 32'd0) begin n_bad++; $display("FAIL midrst_value got %h want 0", dMemValue); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got %b want 0", done); end
    if (stall !== 1'b1) begin n_bad++; $display("FAIL midrst_stall_req got %b want 1", stall); end
    req_valid = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin n_bad++; $display("FAIL midrst_stall got %b want 0", stall); end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    access(1'b0, 32'h40, 32'h0, 2'b00, 1'b0, 0);
    n_cmp += 2;
    if (n !== 3) begin n_bad++; $display("FAIL midrst_accept got %0d want 3", n); end
    if (val !== 32'h55AA55AA) begin n_bad++; $display("FAIL midrst_no_write got %h want 55aa55aa", val); end
  endtask
  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_misalign;
    test_wrap;
    test_latched;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
